// File: rtl/sad_pipe_engine.sv
// Pipelined sum-of-absolute-differences engine: abs-diff, adder tree and accumulate
// stages over LANES elements per beat, with a block-level valid/ready result handshake.
module sad_pipe_engine #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             len,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a_data,
  input  logic [LANES*DATA_W-1:0] b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        sad_out,
  output logic                    ovf,
  output logic                    busy
);

  localparam int SUM_W  = DATA_W + 1 + $clog2(LANES);
  localparam int FULL_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                   state;
  logic [15:0]                  len_q;
  logic [15:0]                  cnt;
  logic                         s1_v;
  logic                         s2_v;
  logic [LANES-1:0][DATA_W:0]   s1_diff;
  logic [LANES-1:0][DATA_W:0]   diff;
  logic [SUM_W-1:0]             s2_sum;
  logic [SUM_W-1:0]             tree_sum;
  logic [ACC_W-1:0]             acc;
  logic                         ovf_q;
  logic [FULL_W-1:0]            acc_full;
  logic                         accept;

  logic signed [DATA_W:0]       ea;
  logic signed [DATA_W:0]       eb;
  logic signed [DATA_W:0]       d;
  logic [DATA_W-1:0]            ua;
  logic [DATA_W-1:0]            ub;

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sad_out   = acc;
  assign ovf       = ovf_q;
  assign accept    = in_valid && (state == RUN);

  // Signed mode widens by one bit so that e.g. -128 vs 127 yields 255 without overflow.
  always_comb begin
    diff = '0;
    ea   = '0;
    eb   = '0;
    d    = '0;
    ua   = '0;
    ub   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      ua = a_data[i*DATA_W +: DATA_W];
      ub = b_data[i*DATA_W +: DATA_W];
      if (SIGNED != 0) begin
        ea = {ua[DATA_W-1], ua};
        eb = {ub[DATA_W-1], ub};
        d  = ea - eb;
        diff[i] = d[DATA_W] ? -d : d;
      end else begin
        diff[i] = (ua >= ub) ? {1'b0, ua - ub} : {1'b0, ub - ua};
      end
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SUM_W'(s1_diff[i]);
    end
  end

  assign acc_full = FULL_W'(acc) + FULL_W'(s2_sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_diff <= '0;
      s2_sum  <= '0;
      acc     <= '0;
      ovf_q   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) s1_diff <= diff;
      s2_v   <= s1_v;
      s2_sum <= tree_sum;
      if (s2_v) begin
        acc <= acc_full[ACC_W-1:0];
        if (|acc_full[FULL_W-1:ACC_W]) ovf_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
            if (len != 16'd0) begin
              len_q <= len;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + 16'd1;
            if (cnt == len_q - 16'd1) state <= DRAIN;
          end
        end
        // Pipeline is empty once both stage valids are low; the accumulate already landed.
        DRAIN: if (!s1_v && !s2_v) state <= DONE;
        DONE:  if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_pipe_engine.sv
// Self-checking bench: three engine configurations driven in lockstep, results
// compared against a behavioural SAD model through a scoreboard queue.
module tb_sad_pipe_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] a_data = '0;
  logic [31:0] b_data = '0;

  logic        ir_u, ov_u, of_u, by_u;
  logic [31:0] sad_u;
  logic        ir_s, ov_s, of_s, by_s;
  logic [31:0] sad_s;
  logic        ir_o, ov_o, of_o, by_o;
  logic [9:0]  sad_o;

  always #5 clk = ~clk;

  sad_pipe_engine #(.DATA_W(8), .LANES(4), .ACC_W(32), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(ir_u), .a_data(a_data), .b_data(b_data),
    .out_valid(ov_u), .out_ready(out_ready), .sad_out(sad_u), .ovf(of_u), .busy(by_u));

  sad_pipe_engine #(.DATA_W(8), .LANES(4), .ACC_W(32), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(ir_s), .a_data(a_data), .b_data(b_data),
    .out_valid(ov_s), .out_ready(out_ready), .sad_out(sad_s), .ovf(of_s), .busy(by_s));

  sad_pipe_engine #(.DATA_W(8), .LANES(4), .ACC_W(10), .SIGNED(0)) dut_o (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(ir_o), .a_data(a_data), .b_data(b_data),
    .out_valid(ov_o), .out_ready(out_ready), .sad_out(sad_o), .ovf(of_o), .busy(by_o));

  typedef struct {
    longint su;
    longint ss;
    longint so;
    bit     fu;
    bit     fs;
    bit     fo;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint m_u, m_s, m_o;
  bit     f_u, f_s, f_o;
  int     cyc;
  logic   seen;
  logic [31:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string t, input logic ir, input logic ov, input logic by);
    check({t, "_in_ready_u"}, ir_u, ir);
    check({t, "_in_ready_s"}, ir_s, ir);
    check({t, "_in_ready_o"}, ir_o, ir);
    check({t, "_out_valid_u"}, ov_u, ov);
    check({t, "_out_valid_s"}, ov_s, ov);
    check({t, "_out_valid_o"}, ov_o, ov);
    check({t, "_busy_u"}, by_u, by);
    check({t, "_busy_s"}, by_s, by);
    check({t, "_busy_o"}, by_o, by);
  endtask

  function automatic int beat_sum(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] xa, xb;
      int ia, ib, dd;
      xa = a[i*8 +: 8];
      xb = b[i*8 +: 8];
      if (sgn) begin
        ia = int'($signed(xa));
        ib = int'($signed(xb));
      end else begin
        ia = int'(xa);
        ib = int'(xb);
      end
      dd = ia - ib;
      if (dd < 0) dd = -dd;
      s += dd;
    end
    return s;
  endfunction

  task automatic acc_add(inout longint m, inout bit f, input longint v, input longint md);
    if (m + v >= md) f = 1'b1;
    m = (m + v) % md;
  endtask

  task automatic model_start();
    m_u = 0; m_s = 0; m_o = 0;
    f_u = 0; f_s = 0; f_o = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.su = m_u; e.ss = m_s; e.so = m_o;
    e.fu = f_u; e.fs = f_s; e.fo = f_o;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    model_start();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("beat_in_ready", ir_u, 1'b1);
    in_valid = 1'b1;
    a_data = a;
    b_data = b;
    acc_add(m_u, f_u, longint'(beat_sum(a, b, 0)), longint'(1) << 32);
    acc_add(m_s, f_s, longint'(beat_sum(a, b, 1)), longint'(1) << 32);
    acc_add(m_o, f_o, longint'(beat_sum(a, b, 0)), 1024);
    @(posedge clk);
  endtask

  // Called at a negedge; counts clock edges until out_valid, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (!ov_u && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic compare_result();
    exp_t e;
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sad_u", sad_u, e.su);
      check("sad_s", sad_s, e.ss);
      check("sad_o", sad_o, e.so);
      check("ovf_u", of_u, e.fu);
      check("ovf_s", of_s, e.fs);
      check("ovf_o", of_o, e.fo);
      check("out_valid_s", ov_s, 1'b1);
      check("out_valid_o", ov_o, 1'b1);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_flags("after_consume", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset_sad_u", sad_u, 0);
    check("reset_sad_o", sad_o, 0);
    check("reset_ovf_u", of_u, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Block A: unsigned pair from the plan, latency of exactly 3 edges
    do_start(16'd2);
    drive_beat({8'd10, 8'd20, 8'd30, 8'd40}, {8'd12, 8'd18, 8'd30, 8'd45});
    drive_beat(32'hFFFF_FFFF, 32'h0000_0000);
    push_exp();
    @(negedge clk);
    in_valid = 1'b0;
    check_flags("drain", 1'b0, 1'b0, 1'b1);
    wait_out(cyc);
    check("latency_edges", cyc, 3);
    check("sad_u_1029", sad_u, 1029);
    compare_result();
    consume();

    // Overflow block: 2040 wraps to 1016 on the 10-bit instance
    do_start(16'd2);
    drive_beat(32'hFFFF_FFFF, 32'h0000_0000);
    drive_beat(32'hFFFF_FFFF, 32'h0000_0000);
    push_exp();
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc);
    check("ovf_latency", cyc, 3);
    check("sad_o_1016", sad_o, 1016);
    check("ovf_o_set", of_o, 1'b1);
    compare_result();
    consume();

    // Signed block: -128 vs 127 per lane; start clears the sticky ovf
    do_start(16'd1);
    check("ovf_cleared_by_start", of_o, 1'b0);
    drive_beat(32'h8080_8080, 32'h7F7F_7F7F);
    push_exp();
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc);
    check("signed_latency", cyc, 3);
    check("sad_s_1020", sad_s, 1020);
    compare_result();

    // Backpressure in DONE with start pulse and in_valid toggling
    held = sad_s;
    for (int i = 0; i < 5; i++) begin
      start    = (i == 2);
      len      = 16'd3;
      in_valid = i[0];
      a_data   = $urandom;
      b_data   = $urandom;
      @(negedge clk);
      check("bp_sad_stable", sad_s, held);
      check_flags("bp", 1'b0, 1'b1, 1'b1);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    consume();
    @(negedge clk);
    check_flags("start_ignored", 1'b0, 1'b0, 1'b0);

    // Zero-length block
    do_start(16'd0);
    push_exp();
    @(negedge clk);
    wait_out(cyc);
    check("len0_latency", cyc, 0);
    check_flags("len0", 1'b0, 1'b1, 1'b1);
    compare_result();
    consume();

    // Abort after 1 of 3 beats
    do_start(16'd3);
    drive_beat(32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_flags("abort", 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | ov_u | ov_s | ov_o;
    end
    check("abort_no_result", seen, 1'b0);
    check("abort_acc_clear", sad_u, 0);

    // Reset asserted mid-DRAIN after the accumulate has landed
    do_start(16'd1);
    drive_beat(32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", by_u, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_flags("async_reset", 1'b0, 1'b0, 1'b0);
    check("async_reset_sad_u", sad_u, 0);
    check("async_reset_sad_s", sad_s, 0);
    check("async_reset_sad_o", sad_o, 0);
    check("async_reset_ovf_o", of_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_flags("post_reset", 1'b0, 1'b0, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
